sipo_deserializer: RTL
======================

# sipo_deserializer

Parametrised serial-in/parallel-out deserializer that generalises the fixed 4-bit SIPO register. It adds configurable word width, selectable bit order, an input qualifier, a bit counter with word framing, and a registered output word with a one-cycle valid strobe. It sits between a serial bit source and word-wide consumers. The raw shift contents remain visible for debug and for legacy SIPO use.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 1, bit order: 1 means the first received bit lands in dout[0]; 0 means the first received bit lands in dout[WIDTH-1].
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous clear of the partial word; active-high.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only on edges where this is 1.
- q  output  WIDTH  live shift-register contents, updated every accepted bit.
- dout  output  WIDTH  last complete word; held until the next word completes.
- dout_valid  output  1  one-cycle pulse, high in the cycle dout takes a new word.
- bit_cnt  output  $clog2(WIDTH)  number of bits accepted in the current partial word.

## Operation
- State: shift register sr (drives q), counter cnt (drives bit_cnt), output register dout, strobe register dout_valid.
- Accepted bit: din_valid=1 and clr=0 at a rising edge.
- Shift on an accepted bit:
  - LSB_FIRST=1: sr <= {din, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], din}.
- Counting: cnt increments by 1 on each accepted bit.
- Word completion: an accepted bit with cnt==WIDTH-1.
  - cnt wraps to 0.
  - dout <= the post-shift value of sr, which includes the current din.
  - dout_valid <= 1.
- No completion on an edge: dout_valid <= 0 and dout holds.
- din_valid=0: sr, cnt and dout hold; dout_valid <= 0.
- clr=1: sr <= 0 and cnt <= 0; dout_valid <= 0; dout holds. clr has priority over a simultaneous din_valid, so that bit is dropped.
- rst_n=0, any time: sr, cnt, dout and dout_valid all go to 0 immediately, independent of clk. A partial word is discarded. Counting restarts from 0 on the first accepted bit after release.
- Back-to-back words with din_valid held high: dout_valid pulses every WIDTH cycles and stays low between pulses. WIDTH>=2 guarantees it is never high for two consecutive cycles.

## Timing
- Reset values: q=0, dout=0, dout_valid=0, bit_cnt=0.
- Latency: dout and dout_valid update at the same edge that samples the last bit of a word, so they are visible 1 cycle after the last bit is presented.
- q reflects each accepted bit after that bit's sampling edge.
- Throughput: 1 bit per cycle; 1 word per WIDTH accepted bits.
- Handshake: no backpressure. A consumer must capture dout while dout_valid=1 or before the next completion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=4, LSB_FIRST=1; reset; feed bits 0,1,1,1 (first to last) with din_valid=1 -> dout=4'hE, dout_valid high for exactly 1 cycle after the 4th bit, bit_cnt back to 0, q=4'hE.
- WIDTH=4, LSB_FIRST=0; same bit sequence 0,1,1,1 -> dout=4'h7; q steps 0,1,3,7.
- WIDTH=8, LSB_FIRST=1; stream 8'hA5 LSB-first with din_valid low for 3 cycles after bits 2 and 5 -> dout=8'hA5; no dout_valid during the gaps; bit_cnt holds through the gaps.
- WIDTH=4; feed 2 bits, pulse clr together with din_valid=1, then feed 1,0,1,1 -> first dout_valid gives dout=4'hD (LSB_FIRST=1); the bit sampled with clr is ignored; dout keeps its old value until then.
- WIDTH=4; complete word 4'hE, feed 2 bits, assert rst_n=0 between clock edges -> dout, q, bit_cnt and dout_valid go to 0 asynchronously; after release, bits 1,0,0,0 -> dout=4'h1.
- WIDTH=4; 3 consecutive words 4'h3, 4'hC, 4'h9 with din_valid held high -> dout_valid pulses at cycles 4, 8 and 12 with the matching dout values, low in all other cycles.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with bit counter, word framing,
// selectable bit order and a registered output word plus valid strobe.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   LSB_FIRST  1: first received bit lands in dout[0];
//              0: first received bit lands in dout[WIDTH-1]
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of the partial word (wins over din_valid)
//   din        serial data bit
//   din_valid  din is accepted only when this is high
//   q          live shift-register contents
//   dout       last complete word, held until the next completion
//   dout_valid one-cycle pulse when dout takes a new word
//   bit_cnt    bits accepted so far in the current partial word
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     din,
    input  logic                     din_valid,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dv_q, dv_d;
    logic             accept;

    assign accept = din_valid && !clr;

    always_comb begin
        shifted = '0;
        if (LSB_FIRST) begin
            shifted = {din, sr_q[WIDTH-1:1]};
        end else begin
            shifted = {sr_q[WIDTH-2:0], din};
        end
    end

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept) begin
            sr_d = shifted;
            if (cnt_q == LAST) begin
                // Completed word includes the bit sampled on this edge.
                cnt_d  = '0;
                dout_d = shifted;
                dv_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    assign q          = sr_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign bit_cnt    = cnt_q;

endmodule
